// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: turns the bipolar P/N rail pair back into NRZ by removing 000V/B00V
// substitutions through a 4-deep mark pipeline, and flags line-code errors.
module hdb3_decoder (
    input  logic clk,
    input  logic reset,
    input  logic P,
    input  logic N,
    output logic data,
    output logic valid,
    output logic err_illegal,
    output logic err_bpv,
    output logic err_zrun
);

    logic       w_pos;
    logic       w_neg;
    logic       w_mark;
    logic       w_viol;
    logic [2:0] w_zcnt_d;
    logic [2:0] w_fill_d;
    logic [3:0] w_sh_d;

    logic [3:0] r_sh;
    logic       r_last_pol;   // 1 = positive
    logic       r_seen;
    logic       r_last_vpol;
    logic       r_vseen;
    logic [2:0] r_zcnt;
    logic [2:0] r_fill;
    logic       r_data;
    logic       r_valid;
    logic       r_err_illegal;
    logic       r_err_bpv;
    logic       r_err_zrun;

    always_comb begin
        w_pos  = P & ~N;
        w_neg  = N & ~P;
        w_mark = w_pos | w_neg;
        // The first pulse after reset is always accepted as a B/AMI pulse.
        w_viol = w_mark & r_seen & (w_pos == r_last_pol);

        w_sh_d   = w_viol ? 4'b0000 : {r_sh[2:0], w_mark};
        w_zcnt_d = w_mark ? 3'd0 : ((r_zcnt == 3'd4) ? 3'd4 : r_zcnt + 3'd1);
        w_fill_d = (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh          <= 4'b0000;
            r_last_pol    <= 1'b0;
            r_seen        <= 1'b0;
            r_last_vpol   <= 1'b0;
            r_vseen       <= 1'b0;
            r_zcnt        <= 3'd0;
            r_fill        <= 3'd0;
            r_data        <= 1'b0;
            r_valid       <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_bpv     <= 1'b0;
            r_err_zrun    <= 1'b0;
        end else begin
            r_data <= r_sh[3];
            r_sh   <= w_sh_d;
            if (w_mark) begin
                r_last_pol <= w_pos;
                r_seen     <= 1'b1;
            end
            if (w_viol) begin
                r_last_vpol <= w_pos;
                r_vseen     <= 1'b1;
            end
            r_err_bpv     <= w_viol & r_vseen & (w_pos == r_last_vpol);
            r_zcnt        <= w_zcnt_d;
            // Saturation at 4 keeps this to a single pulse per zero run.
            r_err_zrun    <= r_seen & ~w_mark & (r_zcnt == 3'd3);
            r_err_illegal <= P & N;
            r_fill        <= w_fill_d;
            r_valid       <= (w_fill_d == 3'd4);
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign err_illegal = r_err_illegal;
    assign err_bpv     = r_err_bpv;
    assign err_zrun    = r_err_zrun;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: directed, random and encoder-loopback segments,
// expectations from a window-based reference model, checked by an independent monitor.
module tb_hdb3_decoder;

    logic clk;
    logic reset;
    logic P;
    logic N;
    logic data;
    logic valid;
    logic err_illegal;
    logic err_bpv;
    logic err_zrun;

    hdb3_decoder u_dut (
        .clk        (clk),
        .reset      (reset),
        .P          (P),
        .N          (N),
        .data       (data),
        .valid      (valid),
        .err_illegal(err_illegal),
        .err_bpv    (err_bpv),
        .err_zrun   (err_zrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] v;      // {valid, data, err_illegal, err_bpv, err_zrun}
        int         seg;
        int         edge_n; // -1 for reset cycles
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] seg_syms[$]; // {P,N}
    bit         seg_bits[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // Monitor: one expectation per clock edge once stimulus has started.
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {valid, data, err_illegal, err_bpv, err_zrun};
                n_cmp++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL seg%0d edge%0d {valid,data,ill,bpv,zrun}: got %b want %b",
                             e.seg, e.edge_n, act, e.v);
                end
            end
        end
    end

    task automatic set_syms(input string s);
        seg_syms.delete();
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+":     seg_syms.push_back(2'b10);
                "-":     seg_syms.push_back(2'b01);
                "X":     seg_syms.push_back(2'b11);
                default: seg_syms.push_back(2'b00);
            endcase
        end
    endtask

    // Reference HDB3 encoder: runs of four zeros become 000V (odd pulse count since last V)
    // or B00V (even), V always repeating the polarity of the preceding pulse.
    task automatic encode_bits();
        bit lastp = 1'b0;
        int nb    = 0;
        int i     = 0;
        int len   = seg_bits.size();
        seg_syms.delete();
        while (i < len) begin
            if (i + 3 < len && !seg_bits[i] && !seg_bits[i+1] && !seg_bits[i+2]
                && !seg_bits[i+3]) begin
                if (nb % 2 == 1) begin
                    seg_syms.push_back(2'b00);
                end else begin
                    lastp = ~lastp;
                    seg_syms.push_back(lastp ? 2'b10 : 2'b01);
                end
                seg_syms.push_back(2'b00);
                seg_syms.push_back(2'b00);
                seg_syms.push_back(lastp ? 2'b10 : 2'b01);
                nb = 0;
                i += 4;
            end else if (seg_bits[i]) begin
                lastp = ~lastp;
                seg_syms.push_back(lastp ? 2'b10 : 2'b01);
                nb++;
                i++;
            end else begin
                seg_syms.push_back(2'b00);
                i++;
            end
        end
    endtask

    // Reset for two cycles, then play seg_syms; loopback expects the raw bits and no errors.
    task automatic run_seg(input int id, input bit lb);
        int   len = seg_syms.size();
        bit   mk[], vio[], bpv[], zr[], ill[], dec[];
        bit   seen = 0, lp = 0, vs = 0, lvp = 0, pl, anyv;
        exp_t e;
        mk = new[len]; vio = new[len]; bpv = new[len];
        zr = new[len]; ill = new[len]; dec = new[len];
        for (int i = 0; i < len; i++) begin
            mk[i]  = (seg_syms[i] == 2'b10) || (seg_syms[i] == 2'b01);
            ill[i] = (seg_syms[i] == 2'b11);
            pl     = (seg_syms[i] == 2'b10);
            vio[i] = mk[i] && seen && (pl == lp);
            bpv[i] = vio[i] && vs && (pl == lvp);
            if (vio[i]) begin vs = 1; lvp = pl; end
            if (mk[i]) begin seen = 1; lp = pl; end
        end
        for (int i = 0; i < len; i++) begin
            zr[i] = (i >= 4) && mk[i-4] && !mk[i-3] && !mk[i-2] && !mk[i-1] && !mk[i];
            anyv  = 0;
            for (int k = i; k <= i + 3 && k < len; k++) anyv |= vio[k];
            dec[i] = lb ? seg_bits[i] : (mk[i] && !anyv);
            if (lb) begin ill[i] = 0; bpv[i] = 0; zr[i] = 0; end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset = 1'b1; P = 1'b0; N = 1'b0;
            e.v = 5'b0; e.seg = id; e.edge_n = -1;
            exp_q.push_back(e);
        end
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            reset  = 1'b0;
            {P, N} = seg_syms[j-1];
            e.v = {(j >= 4), (j >= 5) ? dec[j-5] : 1'b0, ill[j-1], bpv[j-1], zr[j-1]};
            e.seg = id; e.edge_n = j;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        int b;
        reset = 1'b1;
        P     = 1'b0;
        N     = 1'b0;
        set_syms("+-+0-0000");        run_seg(1, 0);
        set_syms("+000+-0000");       run_seg(2, 0);
        set_syms("+-00-+000+0000");   run_seg(3, 0);
        set_syms("+-X+-0000");        run_seg(4, 0);
        set_syms("+00000000");        run_seg(5, 0);
        set_syms("+000+000+0000");    run_seg(6, 0);
        set_syms("+-");               run_seg(7, 0);
        set_syms("-0000");            run_seg(8, 0);
        for (int s = 0; s < 6; s++) begin
            seg_syms.delete();
            for (int i = 0; i < 40; i++) begin
                b = $urandom_range(0, 9);
                seg_syms.push_back(b < 4 ? 2'b00 : b < 7 ? 2'b10 : b < 9 ? 2'b01 : 2'b11);
            end
            run_seg(10 + s, 0);
        end
        seg_bits.delete();
        while (seg_bits.size() < 10000) begin
            if ($urandom_range(0, 3) == 0) begin
                b = $urandom_range(4, 16);
                for (int i = 0; i < b; i++) seg_bits.push_back(1'b0);
            end else begin
                seg_bits.push_back(1'($urandom_range(0, 1)));
            end
        end
        while (seg_bits.size() > 10000) void'(seg_bits.pop_back());
        encode_bits();
        run_seg(20, 1);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
